// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: request op codes, primary opcodes and
// R-format funct values. The control decoder imports the same package.
package mips_pkg;

  typedef enum logic [3:0] {
    INS_ADD  = 4'd0,
    INS_SUB  = 4'd1,
    INS_AND  = 4'd2,
    INS_OR   = 4'd3,
    INS_LW   = 4'd4,
    INS_SW   = 4'd5,
    INS_ADDI = 4'd6,
    INS_ANDI = 4'd7,
    INS_BEQ  = 4'd8
  } instr_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } ldr_state_e;

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational encoder: symbolic op plus register/immediate fields to a
// 32-bit MIPS word. Ops outside the supported subset flag illegal.
module mips_instr_encode
  import mips_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Select R- or I-format layout from the op.
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      INS_ADD:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_ADD};
      INS_SUB:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_SUB};
      INS_AND:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_AND};
      INS_OR:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_OR};
      INS_LW:   word_o = {OP_LW,   rs_i, rt_i, imm_i};
      INS_SW:   word_o = {OP_SW,   rs_i, rt_i, imm_i};
      INS_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i};
      INS_ANDI: word_o = {OP_ANDI, rs_i, rt_i, imm_i};
      INS_BEQ:  word_o = {OP_BEQ,  rs_i, rt_i, imm_i};
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_program_loader.sv
// Program loader: accepts symbolic instruction requests, writes encoded words
// to consecutive instruction-memory addresses and holds the core in reset
// until the load is finished.
module mips_program_loader
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   prog_len,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] LEN_FULL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  ldr_state_e        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_q, cpu_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        fire;

  mips_instr_encode u_encode (
    .op_i      (in_op),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // prog_len doubles as the write pointer; it saturates at DEPTH.
  assign in_ready = (state_q == ST_LOAD) && (len_q < LEN_FULL);
  assign fire     = in_valid && in_ready;

  // Next state, pointer/length, sticky error and write-port registers.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (start)       state_d = ST_LOAD;
        else if (finish) state_d = ST_RUN;
      end
      ST_RUN:  if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
    // start restarts the load and drops any beat accepted this cycle
    if (start) begin
      len_d = '0;
      err_d = 1'b0;
    end else if (fire) begin
      if (enc_illegal) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = len_q[ADDR_W-1:0];
        wdata_d = enc_word;
        len_d   = len_q + LEN_ONE;
      end
    end
    // Core leaves reset only after a full cycle in RUN, so a write issued on
    // the LOAD->RUN edge always lands before the core runs.
    cpu_d = (state_q == ST_RUN) && (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cpu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cpu_q   <= cpu_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_rst_n   = cpu_q;
  assign prog_len    = len_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Bench for mips_program_loader (DEPTH=4): directed vector table followed by
// randomized traffic checked against a behavioural model.
module tb_mips_program_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, finish, in_valid, in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [15:0]   in_imm;
  logic          imem_we, cpu_rst_n, err_illegal;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   prog_len;

  always #5 clk = ~clk;

  mips_program_loader #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .finish      (finish),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_imm      (in_imm),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_rst_n   (cpu_rst_n),
    .prog_len    (prog_len),
    .err_illegal (err_illegal)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic r, s, f, v;
    logic [3:0] op;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic chk_rdy, rdy;
    logic we;
    logic [AW-1:0] addr;
    logic [31:0] wd;
    logic [AW:0] len;
    logic err, cpu;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic r, logic s, logic f, logic v, logic [3:0] op,
                               logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                               logic [15:0] imm, logic cr, logic rdy, logic we,
                               logic [AW-1:0] addr, logic [31:0] wd, logic [AW:0] len,
                               logic err, logic cpu);
    vec_t t;
    t.r = r; t.s = s; t.f = f; t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd;
    t.imm = imm; t.chk_rdy = cr; t.rdy = rdy; t.we = we; t.addr = addr; t.wd = wd;
    t.len = len; t.err = err; t.cpu = cpu;
    return t;
  endfunction

  // Reference encoder from the MIPS opcode/funct tables (decimal values).
  function automatic logic [31:0] ref_word(int op, int rs, int rt, int rd, int imm);
    int opc[9] = '{0, 0, 0, 0, 35, 43, 8, 12, 4};
    int fn[4]  = '{32, 34, 36, 37};
    longint w;
    w = longint'(opc[op]) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536;
    if (op < 4) w += longint'(rd) * 2048 + longint'(fn[op]);
    else        w += longint'(imm);
    return w[31:0];
  endfunction

  // Model: mode 0 idle, 1 loading, 2 running.
  int          m_mode = 0;
  int          m_len  = 0;
  bit          m_err = 0, m_we = 0, m_cpu = 0;
  int          m_addr = 0;
  logic [31:0] m_wd = '0;

  function automatic bit model_ready();
    return (m_mode == 1) && (m_len < DEPTH);
  endfunction

  task automatic model_edge();
    int prev;
    bit fire;
    if (!rst_n) begin
      m_mode = 0; m_len = 0; m_err = 0; m_we = 0; m_addr = 0; m_wd = '0; m_cpu = 0;
    end else begin
      prev = m_mode;
      fire = in_valid && model_ready();
      m_we = 0;
      if (start) begin
        m_mode = 1; m_len = 0; m_err = 0;
      end else begin
        if (fire) begin
          if (int'(in_op) <= 8) begin
            m_we = 1; m_addr = m_len;
            m_wd = ref_word(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
            m_len++;
          end else m_err = 1;
        end
        if (finish && m_mode == 1) m_mode = 2;
      end
      m_cpu = (prev == 2) && (m_mode == 2);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n = t.r; start = t.s; finish = t.f; in_valid = t.v; in_op = t.op;
    in_rs = t.rs; in_rt = t.rt; in_rd = t.rd; in_imm = t.imm;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //             r  s  f  v  op  rs  rt  rd  imm      cr rdy we adr wdata         len err cpu
    tbl.push_back(mkv(0, 0, 0, 0, 0,  0,  0,  0,  16'h0,   0, 0, 0, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 0,  1,  2,  3,  16'h0,   1, 0, 0, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 0, 0,  0,  0,  0,  16'h0,   1, 0, 0, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 0,  1,  2,  3,  16'h0,   1, 1, 1, 0, 32'h00221820, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0,  0,  0,  16'h0,   1, 1, 0, 0, 32'h00221820, 1, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 0, 0,  0,  0,  0,  16'h0,   1, 1, 0, 0, 32'h00221820, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 4,  0,  8,  0,  16'h4,   1, 1, 1, 0, 32'h8C080004, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 5, 29, 31,  0,  16'h8,   1, 1, 1, 1, 32'hAFBF0008, 2, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 0, 0,  0,  0,  0,  16'h0,   1, 1, 0, 1, 32'hAFBF0008, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 8,  1,  2,  0,  16'hFFFF,1, 1, 1, 0, 32'h1022FFFF, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 12, 1,  2,  3,  16'h0,   1, 1, 0, 0, 32'h1022FFFF, 1, 1, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 6,  3,  4,  0,  16'h10,  1, 1, 1, 1, 32'h20640010, 2, 1, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 7,  5,  6,  0,  16'hFF,  1, 1, 1, 2, 32'h30A600FF, 3, 1, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 3,  7,  8,  9,  16'h0,   1, 1, 1, 3, 32'h00E84825, 4, 1, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 1,  1,  1,  1,  16'h0,   1, 0, 0, 3, 32'h00E84825, 4, 1, 0));
    tbl.push_back(mkv(1, 1, 0, 0, 0,  0,  0,  0,  16'h0,   1, 0, 0, 3, 32'h00E84825, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 1, 2,  1,  2,  3,  16'h0,   1, 1, 0, 3, 32'h00E84825, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 1, 1, 2,  1,  2,  3,  16'h0,   1, 1, 1, 0, 32'h00221824, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0,  0,  0,  16'h0,   1, 0, 0, 0, 32'h00221824, 1, 0, 1));
    tbl.push_back(mkv(1, 0, 0, 1, 0,  1,  2,  3,  16'h0,   1, 0, 0, 0, 32'h00221824, 1, 0, 1));
    tbl.push_back(mkv(1, 1, 0, 0, 0,  0,  0,  0,  16'h0,   1, 0, 0, 0, 32'h00221824, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 9,  0,  0,  0,  16'h0,   1, 1, 0, 0, 32'h00221824, 0, 1, 0));
    tbl.push_back(mkv(1, 1, 1, 0, 0,  0,  0,  0,  16'h0,   1, 1, 0, 0, 32'h00221824, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 1, 0,  1,  2,  3,  16'h0,   1, 1, 1, 0, 32'h00221820, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0,  4,  5,  6,  16'h0,   1, 1, 0, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0,  0,  0,  16'h0,   1, 0, 0, 0, 32'h0,        0, 0, 0));

    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; in_op = '0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      if (tbl[i].chk_rdy) check($sformatf("row%0d in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].rdy});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d imem_we", i), {31'b0, imem_we}, {31'b0, tbl[i].we});
      check($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      check($sformatf("row%0d imem_wdata", i), imem_wdata, tbl[i].wd);
      check($sformatf("row%0d prog_len", i), 32'(prog_len), 32'(tbl[i].len));
      check($sformatf("row%0d err_illegal", i), {31'b0, err_illegal}, {31'b0, tbl[i].err});
      check($sformatf("row%0d cpu_rst_n", i), {31'b0, cpu_rst_n}, {31'b0, tbl[i].cpu});
    end

    // DUT is now idle with reset values, matching the model's initial state.
    for (int k = 0; k < 1500; k++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      start    = ($urandom_range(0, 15) == 0);
      finish   = ($urandom_range(0, 11) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      in_rs    = 5'($urandom);
      in_rt    = 5'($urandom);
      in_rd    = 5'($urandom);
      in_imm   = 16'($urandom);
      #1;
      check("rand in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check("rand imem_we", {31'b0, imem_we}, {31'b0, m_we});
      check("rand imem_addr", 32'(imem_addr), 32'(m_addr));
      check("rand imem_wdata", imem_wdata, m_wd);
      check("rand prog_len", 32'(prog_len), 32'(m_len));
      check("rand err_illegal", {31'b0, err_illegal}, {31'b0, m_err});
      check("rand cpu_rst_n", {31'b0, cpu_rst_n}, {31'b0, m_cpu});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
